csr_encoder: RTL and testbench
==============================

Name: csr_encoder

Overview:
- Dense-to-CSR writer: the producer-side counterpart of the CSR sparse matrix-vector multiplier.
- Accepts a dense matrix streamed row-major, one element per handshake.
- Drops zero elements and writes three arrays that the multiplier reads back: sparse values, column indices and row pointers.
- Sits between the host/loader stream and the sparse, column and row-pointer block RAMs.

Parameters:
- N_ROWS, 560, matrix rows per frame (max 1023)
- N_COLS, 560, matrix columns per frame (max 1024)
- NNZ_DEPTH, 16384, capacity of the value/column RAMs (power of two, at most 16384)
- DW, 32, element data width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- start  in  1  single-cycle pulse; begins a frame when IDLE
- in_valid  in  1  dense element valid
- in_ready  out  1  encoder accepts an element this cycle
- in_data  in  DW  dense element (signed; zero means "skip")
- nz_we  out  1  write strobe for the value RAM and the column RAM
- nz_addr  out  14  shared address into the value and column RAMs
- val_data  out  DW  nonzero value
- col_data  out  32  column index, zero-extended
- row_we  out  1  row-pointer RAM write strobe
- row_addr  out  10  row-pointer index
- row_data  out  32  row-pointer value (nnz count before this row)
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse when the frame is complete
- overflow  out  1  sticky; nonzero count exceeded NNZ_DEPTH during this frame
- nnz_count  out  15  total nonzeros seen in the current or last frame

Behaviour:
- Reset (rst=0 at a posedge):
  - State goes to IDLE.
  - All outputs go to 0: in_ready, nz_we, row_we, busy, done, overflow, nnz_count, and every address and data output.
  - Reset mid-frame abandons the frame. No further writes are issued, and the RAM contents are left as they are.
- States:
  - IDLE: start=1 moves to STREAM. On entry, clear the row/column counters, nnz_count and overflow; set busy=1.
  - STREAM: in_ready=1. A beat is accepted when in_valid && in_ready.
  - FLUSH: a single cycle that writes the final row pointer.
  - DONE: a single cycle with done=1 and busy=0, then back to IDLE.
- start while not in IDLE is ignored.
- Per accepted beat at (row r, column c), all writes are registered and appear on the cycle after acceptance:
  - If c==0: row_we=1, row_addr=r, row_data=nnz_count at that moment, counting only beats before this one.
  - If in_data!=0 and nnz_count<NNZ_DEPTH: nz_we=1, nz_addr=nnz_count[13:0], val_data=in_data, col_data=c. nnz_count increments.
  - If in_data!=0 and nnz_count==NNZ_DEPTH: no write; overflow is set; nnz_count saturates at NNZ_DEPTH.
  - A row-pointer write and a nonzero write may occur in the same cycle. They target different RAMs, so there is no conflict.
- Strobes are single-cycle, valid only in the cycle after acceptance. No writes occur in cycles with no accepted beat.
- Counters:
  - c wraps from N_COLS-1 to 0, and r increments on that wrap.
  - The beat at (N_ROWS-1, N_COLS-1) moves the FSM to FLUSH. in_ready drops in the following cycle.
- FLUSH: row_we=1, row_addr=N_ROWS, row_data=final nnz_count. This happens one cycle after the last beat's writes.
- Latency: done is asserted 3 cycles after the last accepted beat (write, FLUSH, DONE).
- in_valid low stalls the stream. Counters hold and no writes are issued.
- All-zero row: its pointer equals the next row's pointer. This is the condition the multiplier's comparator detects as G (empty row).
- nnz_count holds its value after the frame until the next start.
- Width rules: column index is 10 bits internally, zero-extended to 32. Row-pointer values are 15 bits, zero-extended to 32.

Decomposition:
- Shared package csr_pkg holds:
  - FSM state enum (IDLE, STREAM, FLUSH, DONE)
  - address widths (NZ_AW=14, ROW_AW=10)
  - default N_ROWS/N_COLS (560)
- One natural sub-module, csr_rc_counter: the row/column position counter with its last-element flag. The FSM and write pipeline stay in the top level.

Test Plan:
- 3x4 matrix [[0,5,0,7],[0,0,0,0],[2,0,0,-1]], continuous in_valid:
  - value writes 5,7,2,-1 at addresses 0..3
  - column writes 1,3,0,3
  - row-pointer writes 0,2,2,4 at addresses 0..3
  - done pulses 3 cycles after the last beat
- Same matrix with in_valid toggled every other cycle:
  - identical RAM write sequence
  - no writes during idle cycles
  - done 3 cycles after the last accepted beat
- All-zero 2x2 matrix:
  - no nz_we ever
  - row pointers 0,0,0
  - nnz_count=0
- NNZ_DEPTH=4 with a 2x4 all-ones matrix:
  - nz_we fires exactly 4 times (addresses 0..3)
  - overflow=1 from the 5th nonzero onward
  - nnz_count=4
  - final row pointer 4
- rst=0 asserted in the middle of row 1:
  - all outputs 0 next cycle, state IDLE
  - a following start re-encodes from nz_addr=0, row_addr=0
- start pulsed during STREAM: ignored, and the output sequence is unchanged.

Source files
------------

// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - shared types and widths for the dense-to-CSR encoder
package csr_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int NZ_AW      = 14;
  localparam int ROW_AW     = 10;
  localparam int COL_W      = 10;
  localparam int CNT_W      = 15;
  localparam int DEF_N_ROWS = 560;
  localparam int DEF_N_COLS = 560;

endpackage

// File: rtl/csr_rc_counter.sv
// rtl/csr_rc_counter.sv - row-major position counter with last-element flag
module csr_rc_counter
  import csr_pkg::*;
#(
  parameter int N_ROWS = DEF_N_ROWS,
  parameter int N_COLS = DEF_N_COLS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              step_i,
  output logic [ROW_AW-1:0] row_o,
  output logic [COL_W-1:0]  col_o,
  output logic              last_o
);

  localparam logic [ROW_AW-1:0] LAST_ROW = ROW_AW'(N_ROWS - 1);
  localparam logic [COL_W-1:0]  LAST_COL = COL_W'(N_COLS - 1);

  logic [ROW_AW-1:0] row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clear_i) begin
      row_d = '0;
      col_d = '0;
    end else if (step_i) begin
      if (col_q == LAST_COL) begin
        col_d = '0;
        row_d = row_q + ROW_AW'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row_o  = row_q;
  assign col_o  = col_q;
  assign last_o = (row_q == LAST_ROW) && (col_q == LAST_COL);

endmodule

// File: rtl/csr_encoder.sv
// rtl/csr_encoder.sv - dense row-major stream to CSR value/column/row-pointer RAM writer
module csr_encoder
  import csr_pkg::*;
#(
  parameter int N_ROWS    = DEF_N_ROWS,
  parameter int N_COLS    = DEF_N_COLS,
  parameter int NNZ_DEPTH = 16384,
  parameter int DW        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW-1:0]     in_data,
  output logic              nz_we,
  output logic [NZ_AW-1:0]  nz_addr,
  output logic [DW-1:0]     val_data,
  output logic [31:0]       col_data,
  output logic              row_we,
  output logic [ROW_AW-1:0] row_addr,
  output logic [31:0]       row_data,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [CNT_W-1:0]  nnz_count
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    nnz_q, nnz_d;
  logic                ovf_q, ovf_d;
  logic                in_ready_q, in_ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                nz_we_q, nz_we_d;
  logic [NZ_AW-1:0]    nz_addr_q, nz_addr_d;
  logic [DW-1:0]       val_q, val_d;
  logic [31:0]         col_q, col_d;
  logic                row_we_q, row_we_d;
  logic [ROW_AW-1:0]   row_addr_q, row_addr_d;
  logic [31:0]         row_data_q, row_data_d;

  logic                cnt_clear, cnt_step, last;
  logic [ROW_AW-1:0]   cur_row;
  logic [COL_W-1:0]    cur_col;
  logic                accept;

  csr_rc_counter #(.N_ROWS(N_ROWS), .N_COLS(N_COLS)) u_rc (
    .clk     (clk),
    .rst     (rst),
    .clear_i (cnt_clear),
    .step_i  (cnt_step),
    .row_o   (cur_row),
    .col_o   (cur_col),
    .last_o  (last)
  );

  assign accept = in_valid && in_ready_q;

  // Every output is registered from next-state, so writes land the cycle after acceptance.
  always_comb begin
    state_d    = state_q;
    nnz_d      = nnz_q;
    ovf_d      = ovf_q;
    in_ready_d = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    nz_we_d    = 1'b0;
    nz_addr_d  = nz_addr_q;
    val_d      = val_q;
    col_d      = col_q;
    row_we_d   = 1'b0;
    row_addr_d = row_addr_q;
    row_data_d = row_data_q;
    cnt_clear  = 1'b0;
    cnt_step   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = STREAM;
          cnt_clear  = 1'b1;
          nnz_d      = '0;
          ovf_d      = 1'b0;
          busy_d     = 1'b1;
          in_ready_d = 1'b1;
        end
      end
      STREAM: begin
        in_ready_d = 1'b1;
        if (accept) begin
          cnt_step = 1'b1;
          if (cur_col == '0) begin
            row_we_d   = 1'b1;
            row_addr_d = cur_row;
            row_data_d = 32'(nnz_q);
          end
          if (in_data != '0) begin
            if (nnz_q < CNT_W'(NNZ_DEPTH)) begin
              nz_we_d   = 1'b1;
              nz_addr_d = nnz_q[NZ_AW-1:0];
              val_d     = in_data;
              col_d     = 32'(cur_col);
              nnz_d     = nnz_q + CNT_W'(1);
            end else begin
              ovf_d = 1'b1;
            end
          end
          if (last) begin
            state_d    = FLUSH;
            in_ready_d = 1'b0;
          end
        end
      end
      FLUSH: begin
        row_we_d   = 1'b1;
        row_addr_d = ROW_AW'(N_ROWS);
        row_data_d = 32'(nnz_q);
        state_d    = DONE;
      end
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      nnz_q      <= '0;
      ovf_q      <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      nz_we_q    <= 1'b0;
      nz_addr_q  <= '0;
      val_q      <= '0;
      col_q      <= '0;
      row_we_q   <= 1'b0;
      row_addr_q <= '0;
      row_data_q <= '0;
    end else begin
      state_q    <= state_d;
      nnz_q      <= nnz_d;
      ovf_q      <= ovf_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      nz_we_q    <= nz_we_d;
      nz_addr_q  <= nz_addr_d;
      val_q      <= val_d;
      col_q      <= col_d;
      row_we_q   <= row_we_d;
      row_addr_q <= row_addr_d;
      row_data_q <= row_data_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overflow  = ovf_q;
  assign nnz_count = nnz_q;
  assign nz_we     = nz_we_q;
  assign nz_addr   = nz_addr_q;
  assign val_data  = val_q;
  assign col_data  = col_q;
  assign row_we    = row_we_q;
  assign row_addr  = row_addr_q;
  assign row_data  = row_data_q;

endmodule

// File: tb/tb_csr_encoder.sv
// tb/tb_csr_encoder.sv - randomized self-checking bench for csr_encoder against a CSR reference model
module tb_csr_encoder;

  localparam int R     = 3;
  localparam int C     = 4;
  localparam int NE    = R * C;
  localparam int DEPTH = 4;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, nz_we, row_we, busy, done, overflow;
  logic [13:0]   nz_addr;
  logic [DW-1:0] val_data;
  logic [31:0]   col_data, row_data;
  logic [9:0]    row_addr;
  logic [14:0]   nnz_count;

  always #5 clk = ~clk;

  csr_encoder #(.N_ROWS(R), .N_COLS(C), .NNZ_DEPTH(DEPTH), .DW(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .nz_we(nz_we), .nz_addr(nz_addr), .val_data(val_data),
    .col_data(col_data), .row_we(row_we), .row_addr(row_addr), .row_data(row_data),
    .busy(busy), .done(done), .overflow(overflow), .nnz_count(nnz_count)
  );

  typedef struct {int cyc; int addr; int data; int col;} wr_t;

  wr_t  nz_log[$];
  wr_t  row_log[$];
  int   acc_log[$];
  int   done_log[$];
  int   ovf_cyc = -1;
  logic ovf_prev = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   mat[NE];

  // Acceptance logged at cycle k means that beat's writes must show up at cycle k+1.
  always @(negedge clk) begin
    cyc++;
    if (in_valid && in_ready) acc_log.push_back(cyc);
    if (nz_we) nz_log.push_back('{cyc, int'(nz_addr), int'(val_data), int'(col_data)});
    if (row_we) row_log.push_back('{cyc, int'(row_addr), int'(row_data), 0});
    if (done) done_log.push_back(cyc);
    if (overflow && !ovf_prev) ovf_cyc = cyc;
    ovf_prev = overflow;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic check_outputs_zero(input string p);
    check({p, "_in_ready"}, 32'(in_ready), 0);
    check({p, "_nz_we"}, 32'(nz_we), 0);
    check({p, "_row_we"}, 32'(row_we), 0);
    check({p, "_busy"}, 32'(busy), 0);
    check({p, "_done"}, 32'(done), 0);
    check({p, "_overflow"}, 32'(overflow), 0);
    check({p, "_nnz_count"}, 32'(nnz_count), 0);
    check({p, "_nz_addr"}, 32'(nz_addr), 0);
    check({p, "_val_data"}, val_data, 0);
    check({p, "_col_data"}, col_data, 0);
    check({p, "_row_addr"}, 32'(row_addr), 0);
    check({p, "_row_data"}, row_data, 0);
  endtask

  // CSR reference: pointer of row r is the (saturated) count of nonzeros preceding element r*C.
  task automatic check_frame();
    wr_t enz[$];
    wr_t erow[$];
    int  cnt = 0;
    int  exp_ovf = -1;
    int  fin;
    if (acc_log.size() != NE) return;
    for (int k = 0; k < NE; k++) begin
      if (k % C == 0) erow.push_back('{acc_log[k] + 1, k / C, (cnt < DEPTH) ? cnt : DEPTH, 0});
      if (mat[k] != 0) begin
        if (cnt < DEPTH) enz.push_back('{acc_log[k] + 1, cnt, mat[k], k % C});
        else if (exp_ovf < 0) exp_ovf = acc_log[k] + 1;
        cnt++;
      end
    end
    fin = (cnt < DEPTH) ? cnt : DEPTH;
    erow.push_back('{acc_log[NE-1] + 2, R, fin, 0});
    check("nz_write_count", nz_log.size(), enz.size());
    for (int i = 0; i < enz.size() && i < nz_log.size(); i++) begin
      check("nz_cycle", nz_log[i].cyc, enz[i].cyc);
      check("nz_addr", nz_log[i].addr, enz[i].addr);
      check("val_data", nz_log[i].data, enz[i].data);
      check("col_data", nz_log[i].col, enz[i].col);
    end
    check("row_write_count", row_log.size(), erow.size());
    for (int i = 0; i < erow.size() && i < row_log.size(); i++) begin
      check("row_cycle", row_log[i].cyc, erow[i].cyc);
      check("row_addr", row_log[i].addr, erow[i].addr);
      check("row_data", row_log[i].data, erow[i].data);
    end
    check("nnz_count", 32'(nnz_count), fin);
    check("overflow", 32'(overflow), 32'(cnt > DEPTH));
    check("overflow_cycle", ovf_cyc, exp_ovf);
    check("done_pulses", done_log.size(), 1);
    if (done_log.size() > 0) check("done_cycle", done_log[0], acc_log[NE-1] + 3);
    check("idle_in_ready", 32'(in_ready), 0);
    check("idle_busy", 32'(busy), 0);
  endtask

  // mode 0: continuous valid, 1: toggled, 2: random; abort_at asserts reset before that beat.
  task automatic run_frame(input int mode, input int abort_at, input int start_at);
    int idx = 0;
    int guard = 0;
    logic tog = 1'b0;
    logic v, acc;
    int nwr;
    nz_log.delete(); row_log.delete(); acc_log.delete(); done_log.delete();
    ovf_cyc = -1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("busy_after_start", 32'(busy), 1);
    while (idx < NE && guard < 400) begin
      if (idx == abort_at) begin
        rst = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        check_outputs_zero("abort");
        rst = 1'b1;
        nwr = nz_log.size() + row_log.size();
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_writes", nz_log.size() + row_log.size(), nwr);
        check("abort_stays_idle", 32'(in_ready), 0);
        return;
      end
      case (mode)
        0: v = 1'b1;
        1: begin v = tog; tog = ~tog; end
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      in_valid = v;
      in_data  = v ? mat[idx] : $urandom;
      start    = (idx == start_at);
      acc      = v && in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      guard++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    check("frame_accepted_all", idx, NE);
    repeat (6) @(posedge clk);
    #1;
    check_frame();
  endtask

  task automatic load_plan();
    int plan[NE] = '{0, 5, 0, 7, 0, 0, 0, 0, 2, 0, 0, -1};
    mat = plan;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b1;

    load_plan();
    run_frame(0, -1, -1);
    run_frame(1, -1, -1);
    for (int k = 0; k < NE; k++) mat[k] = 0;
    run_frame(0, -1, -1);
    for (int k = 0; k < NE; k++) mat[k] = 1;
    run_frame(0, -1, -1);
    load_plan();
    run_frame(0, 6, -1);
    run_frame(0, -1, -1);
    run_frame(0, -1, 5);

    for (int f = 0; f < 20; f++) begin
      int dens = $urandom_range(0, 4);
      for (int k = 0; k < NE; k++) mat[k] = ($urandom_range(0, 3) < dens) ? int'($urandom) : 0;
      run_frame(2, -1, ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, NE - 1)) : -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
